// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: frames three RX bytes (A, B, opcode) into ALU operands,
// captures the ALU result and pushes it to the TX FIFO as one byte.
// An inter-byte timeout drops partial frames so the host can resync.
module uart_alu_ctrl #(
  parameter int NB_DATA     = 8,
  parameter int NB_OP       = 6,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int NB_TIMEOUT  = 20
) (
  input  logic               i_clk,
  input  logic               reset,
  input  logic               rx_empty,
  input  logic [NB_DATA-1:0] r_data,
  output logic               rd_uart,
  input  logic               tx_full,
  output logic [NB_DATA-1:0] w_data,
  output logic               wr_uart,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic               o_busy,
  output logic               o_frame_err
);

  localparam int unsigned            TO_LAST  = TIMEOUT_CYC - 1;
  localparam logic [NB_TIMEOUT-1:0]  TO_LIMIT = TO_LAST[NB_TIMEOUT-1:0];

  typedef enum logic [2:0] {
    S_A,
    S_B,
    S_OP,
    S_EXEC,
    S_SEND
  } state_t;

  state_t                 state_q, state_d;
  logic [NB_DATA-1:0]     a_q, a_d;
  logic [NB_DATA-1:0]     b_q, b_d;
  logic [NB_OP-1:0]       op_q, op_d;
  logic [NB_DATA-1:0]     wdata_q, wdata_d;
  logic                   rd_q, rd_d;
  logic                   wr_q, wr_d;
  logic                   err_q, err_d;
  logic [NB_TIMEOUT-1:0]  cnt_q, cnt_d;
  logic                   accept;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, byte capture, timeout and FIFO strobe decisions.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    // A pop issued last cycle has not reached the FIFO yet, so the head
    // word is stale for one cycle; skip evaluation while rd_q is high.
    accept  = !rx_empty && !rd_q;

    case (state_q)
      S_A: begin
        cnt_d = '0;
        if (accept) begin
          a_d     = r_data;
          rd_d    = 1'b1;
          state_d = S_B;
        end
      end
      S_B, S_OP: begin
        // Accept has priority over the timeout firing in the same cycle.
        if (accept) begin
          cnt_d = '0;
          rd_d  = 1'b1;
          if (state_q == S_B) begin
            b_d     = r_data;
            state_d = S_OP;
          end else begin
            op_d    = r_data[NB_OP-1:0];
            state_d = S_EXEC;
          end
        end else if (cnt_q == TO_LIMIT) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_A;
        end else if (rx_empty) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXEC: begin
        cnt_d   = '0;
        wdata_d = i_alu_result;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!tx_full) begin
          wr_d    = 1'b1;
          state_d = S_A;
        end
      end
      default: state_d = S_A;
    endcase
  end

  assign rd_uart     = rd_q;
  assign wr_uart     = wr_q;
  assign o_frame_err = err_q;
  assign w_data      = wdata_q;
  assign o_alu_a     = a_q;
  assign o_alu_b     = b_q;
  assign o_alu_op    = op_q;
  assign o_busy      = (state_q != S_A);

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Scoreboard bench for uart_alu_ctrl: an RX FIFO model feeds bytes, a model
// ALU closes the loop, expected TX bytes are queued per issued frame and a
// negedge monitor pops and compares each TX push.
module tb_uart_alu_ctrl;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int TO_CYC  = 16;
  localparam int NB_TO   = 5;

  logic               clk = 1'b0;
  logic               reset;
  logic               rx_empty;
  logic [NB_DATA-1:0] r_data;
  logic               rd_uart;
  logic               tx_full;
  logic [NB_DATA-1:0] w_data;
  logic               wr_uart;
  logic [NB_DATA-1:0] alu_a;
  logic [NB_DATA-1:0] alu_b;
  logic [NB_OP-1:0]   alu_op;
  logic [NB_DATA-1:0] alu_res;
  logic               busy;
  logic               ferr;

  always #5 clk = ~clk;

  uart_alu_ctrl #(
    .NB_DATA    (NB_DATA),
    .NB_OP      (NB_OP),
    .TIMEOUT_CYC(TO_CYC),
    .NB_TIMEOUT (NB_TO)
  ) dut (
    .i_clk       (clk),
    .reset       (reset),
    .rx_empty    (rx_empty),
    .r_data      (r_data),
    .rd_uart     (rd_uart),
    .tx_full     (tx_full),
    .w_data      (w_data),
    .wr_uart     (wr_uart),
    .o_alu_a     (alu_a),
    .o_alu_b     (alu_b),
    .o_alu_op    (alu_op),
    .i_alu_result(alu_res),
    .o_busy      (busy),
    .o_frame_err (ferr)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference ALU in plain integer arithmetic (MIPS-style funct codes).
  function automatic logic [7:0] alu_ref(input int a, input int b, input int op);
    int r;
    case (op)
      32:      r = a + b;
      34:      r = a - b;
      36:      r = a & b;
      37:      r = a | b;
      38:      r = a ^ b;
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  always_comb alu_res = alu_ref(int'(alu_a), int'(alu_b), int'(alu_op));

  // RX FIFO model: written by the stimulus, popped on rd_uart.
  logic [7:0] rx_mem [256];
  int rx_wr = 0;
  int rx_rd = 0;
  assign rx_empty = (rx_wr == rx_rd);
  assign r_data   = rx_mem[rx_rd % 256];

  always @(posedge clk) begin
    if (rd_uart && !rx_empty) rx_rd <= rx_rd + 1;
  end

  // Scoreboard monitor.
  logic [7:0] exp_q[$];
  int wr_cyc_log[$];
  int cyc = 0;
  int n_rd = 0, n_wr = 0, n_err = 0;
  int last_rd_cyc = 0, last_wr_cyc = 0, last_err_cyc = 0;
  logic rd_prev = 1'b0, err_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (rd_uart) begin
        n_rd++;
        last_rd_cyc = cyc;
        chk("rd_legal{empty,back2back}", {30'd0, rx_empty, rd_prev}, 32'd0);
      end
      if (wr_uart) begin
        n_wr++;
        last_wr_cyc = cyc;
        wr_cyc_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tx_unexpected: got 0x%0h with no frame outstanding", w_data);
        end else begin
          chk("tx_data", {24'd0, w_data}, {24'd0, exp_q.pop_front()});
        end
      end
      if (ferr) begin
        n_err++;
        last_err_cyc = cyc;
        chk("ferr_single_pulse", {31'd0, err_prev}, 32'd0);
      end
    end
    rd_prev  = rd_uart;
    err_prev = ferr;
  end

  // Stimulus helpers (run at negedge + 1 so monitor updates are visible).
  logic rand_tx = 1'b0;

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      if (rand_tx) tx_full = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_mem[rx_wr % 256] = b;
    rx_wr++;
  endtask

  task automatic push_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] opb, input int gap_max);
    exp_q.push_back(alu_ref(int'(a), int'(b), int'(opb[5:0])));
    push(a);
    tick($urandom_range(0, gap_max));
    push(b);
    tick($urandom_range(0, gap_max));
    push(opb);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int t = 0;
    tick(3);
    while (!(rx_empty && !busy && !rd_uart && exp_q.size() == 0) && t < budget) begin
      tick(1);
      t++;
    end
    if (t >= budget) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: busy=%0b rx_left=%0d tx_pending=%0d expected idle within %0d cycles",
               name, busy, rx_wr - rx_rd, exp_q.size(), budget);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd"},   {31'd0, rd_uart}, 32'd0);
    chk({tag, "_wr"},   {31'd0, wr_uart}, 32'd0);
    chk({tag, "_ferr"}, {31'd0, ferr},    32'd0);
    chk({tag, "_busy"}, {31'd0, busy},    32'd0);
    chk({tag, "_a"},    {24'd0, alu_a},   32'd0);
    chk({tag, "_b"},    {24'd0, alu_b},   32'd0);
    chk({tag, "_op"},   {26'd0, alu_op},  32'd0);
    chk({tag, "_wdat"}, {24'd0, w_data},  32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base_rd, base_wr, base_err, t, bad_wr, bad_d, d, k;
    logic [7:0] ops [5];
    logic [7:0] ob;
    ops[0] = 8'h20; ops[1] = 8'h22; ops[2] = 8'h24; ops[3] = 8'h25; ops[4] = 8'h26;

    reset   = 1'b1;
    tx_full = 1'b0;
    tick(2);
    chk_zero("reset");
    reset = 1'b0;
    tick(2);

    // Single ADD frame, latency opcode pop -> TX push.
    base_rd = n_rd; base_wr = n_wr;
    push_frame(8'h05, 8'h03, 8'h20, 0);
    wait_idle("add", 200);
    chk("add_a",     {24'd0, alu_a}, 32'h05);
    chk("add_b",     {24'd0, alu_b}, 32'h03);
    chk("add_op",    {26'd0, alu_op}, 32'h20);
    chk("add_pops",  n_rd - base_rd, 3);
    chk("add_pushes", n_wr - base_wr, 1);
    chk("add_busy",  {31'd0, busy}, 32'd0);
    chk("add_latency", last_wr_cyc - last_rd_cyc, 2);

    // Back-to-back frames preloaded: order, pop count, 7-cycle period.
    base_rd = n_rd; base_wr = n_wr;
    push_frame(8'h10, 8'h20, 8'h22, 0);
    push_frame(8'hF0, 8'h0F, 8'h24, 0);
    wait_idle("b2b", 200);
    chk("b2b_pops",   n_rd - base_rd, 6);
    chk("b2b_pushes", n_wr - base_wr, 2);
    if (wr_cyc_log.size() >= 2)
      chk("b2b_period", wr_cyc_log[wr_cyc_log.size()-1] - wr_cyc_log[wr_cyc_log.size()-2], 7);

    // TX full back-pressure held for 50 cycles.
    tx_full = 1'b1;
    base_rd = n_rd;
    push_frame(8'h7F, 8'h01, 8'h20, 0);
    t = 0;
    while (n_rd - base_rd < 3 && t < 50) begin tick(1); t++; end
    chk("hold_pops", n_rd - base_rd, 3);
    tick(3);
    bad_wr = 0; bad_d = 0;
    for (int i = 0; i < 50; i++) begin
      if (wr_uart) bad_wr++;
      if (w_data !== 8'h80) bad_d++;
      tick(1);
    end
    chk("hold_no_wr",  bad_wr, 0);
    chk("hold_wdata_stable", bad_d, 0);
    chk("hold_busy",   {31'd0, busy}, 32'd1);
    tx_full = 1'b0;
    tick(1);
    chk("hold_release_wr", {31'd0, wr_uart}, 32'd1);
    wait_idle("hold", 100);

    // Partial frame timeout, registers kept, then recovery.
    base_err = n_err; base_wr = n_wr;
    push(8'h11);
    push(8'h22);
    wait_idle("tmo", 200);
    chk("tmo_err_count", n_err - base_err, 1);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    chk("tmo_a_kept", {24'd0, alu_a}, 32'h11);
    chk("tmo_b_kept", {24'd0, alu_b}, 32'h22);
    chk("tmo_no_push", n_wr - base_wr, 0);
    d = last_err_cyc - last_rd_cyc;
    chk("tmo_timing_window", {31'd0, (d >= TO_CYC - 1 && d <= TO_CYC + 2)}, 32'd1);
    push_frame(8'h01, 8'h01, 8'h20, 0);
    wait_idle("tmo_recover", 200);
    chk("tmo_recover_err", n_err - base_err, 1);

    // Opcode upper bits ignored.
    push_frame(8'h12, 8'h34, 8'hE0, 0);
    wait_idle("opmask", 200);
    chk("opmask_op", {26'd0, alu_op}, 32'h20);

    // Reset after operand B pop aborts the frame.
    base_rd = n_rd;
    push(8'hAA);
    push(8'hBB);
    t = 0;
    while (n_rd - base_rd < 2 && t < 50) begin tick(1); t++; end
    chk("mid_pops", n_rd - base_rd, 2);
    tick(1);
    reset = 1'b1;
    tick(1);
    chk_zero("midreset");
    reset = 1'b0;
    base_wr = n_wr;
    push_frame(8'h03, 8'h04, 8'h22, 0);
    wait_idle("midreset", 200);
    chk("midreset_pushes", n_wr - base_wr, 1);
    chk("midreset_a", {24'd0, alu_a}, 32'h03);

    // Randomized frames with byte gaps and random TX back-pressure.
    rand_tx = 1'b1;
    for (int f = 0; f < 30; f++) begin
      k  = $urandom_range(0, 4);
      ob = ops[k] | (8'($urandom_range(0, 3)) << 6);
      push_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), ob, 4);
      tick($urandom_range(0, 6));
    end
    wait_idle("random", 3000);
    rand_tx = 1'b0;
    tx_full = 1'b0;
    tick(2);

    chk("total_frame_errs", n_err, 1);
    chk("rx_drained", rx_wr - rx_rd, 0);
    chk("tx_outstanding", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
